// File: rtl/execute_stage.sv
// Y86 execute stage: ALU, condition codes, cmov squash and the E/M register.
// Define EXEC_HALT_LATCH_EN to latch halted on a captured halt or bad icode.
module execute_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [3:0]  icode,
  input  logic [3:0]  ifun,
  input  logic [31:0] valA,
  input  logic [31:0] valB,
  input  logic [31:0] valC,
  input  logic [3:0]  dstE,
  input  logic [3:0]  dstM,
  input  logic        stall,
  input  logic        bubble,
  output logic        out_valid,
  output logic [3:0]  out_icode,
  output logic        out_Cnd,
  output logic [31:0] out_valE,
  output logic [31:0] out_valA,
  output logic [3:0]  out_dstE,
  output logic [3:0]  out_dstM,
  output logic        ZF,
  output logic        SF,
  output logic        OF,
  output logic        halted
);

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_RRMV = 4'h2;
  localparam logic [3:0] I_IRMV = 4'h3;
  localparam logic [3:0] I_RMMV = 4'h4;
  localparam logic [3:0] I_MRMV = 4'h5;
  localparam logic [3:0] I_OPL  = 4'h6;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] I_PUSH = 4'hA;
  localparam logic [3:0] I_POP  = 4'hB;
  localparam logic [3:0] R_NONE = 4'hF;

  logic        valid_q, valid_d;
  logic [3:0]  icode_q, icode_d;
  logic        cnd_q, cnd_d;
  logic [31:0] vale_q, vale_d;
  logic [31:0] vala_q, vala_d;
  logic [3:0]  dste_q, dste_d;
  logic [3:0]  dstm_q, dstm_d;
  logic        zf_q, zf_d;
  logic        sf_q, sf_d;
  logic        of_q, of_d;

  logic [31:0] alu_a, alu_b, alu_r;
  logic [3:0]  alu_fn;
  logic        alu_of, cnd, take;
  logic        halt_now;

  always_comb begin
    alu_a = 32'd0;
    unique case (icode)
      I_RRMV, I_OPL:         alu_a = valA;
      I_IRMV, I_RMMV, I_MRMV: alu_a = valC;
      I_CALL, I_PUSH:        alu_a = -32'sd4;
      I_RET, I_POP:          alu_a = 32'd4;
      default:               alu_a = 32'd0;
    endcase
  end

  always_comb begin
    alu_b = 32'd0;
    unique case (icode)
      I_RMMV, I_MRMV, I_OPL, I_CALL,
      I_RET, I_PUSH, I_POP: alu_b = valB;
      default:              alu_b = 32'd0;
    endcase
  end

  always_comb begin
    alu_fn = (icode == I_OPL) ? ifun : 4'd0;
    alu_r  = alu_b + alu_a;
    alu_of = (alu_a[31] == alu_b[31]) && (alu_r[31] != alu_a[31]);
    unique case (alu_fn)
      4'd1: begin
        alu_r  = alu_b - alu_a;
        alu_of = (alu_b[31] != alu_a[31]) && (alu_r[31] != alu_b[31]);
      end
      4'd2: begin
        alu_r  = alu_b & alu_a;
        alu_of = 1'b0;
      end
      4'd3: begin
        alu_r  = alu_b ^ alu_a;
        alu_of = 1'b0;
      end
      default: ;
    endcase
  end

  // Condition uses the CC value before this instruction's own update.
  always_comb begin
    cnd = 1'b0;
    unique case (ifun)
      4'd0:    cnd = 1'b1;
      4'd1:    cnd = (sf_q ^ of_q) | zf_q;
      4'd2:    cnd = sf_q ^ of_q;
      4'd3:    cnd = zf_q;
      4'd4:    cnd = ~zf_q;
      4'd5:    cnd = ~(sf_q ^ of_q);
      4'd6:    cnd = ~(sf_q ^ of_q) & ~zf_q;
      default: cnd = 1'b0;
    endcase
  end

`ifdef EXEC_HALT_LATCH_EN
  logic halted_q, halted_d;
  logic halt_in;

  assign halt_in  = (icode == I_HALT) || (icode > I_POP);
  assign halt_now = halted_q;
  assign halted   = halted_q;

  always_comb begin
    halted_d = halted_q;
    if (!stall && take && halt_in)
      halted_d = 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) halted_q <= 1'b0;
    else     halted_q <= halted_d;
  end
`else
  assign halt_now = 1'b0;
  assign halted   = 1'b0;
`endif

  assign take = in_valid && !bubble && !halt_now;

  always_comb begin
    valid_d = valid_q;
    icode_d = icode_q;
    cnd_d   = cnd_q;
    vale_d  = vale_q;
    vala_d  = vala_q;
    dste_d  = dste_q;
    dstm_d  = dstm_q;
    zf_d    = zf_q;
    sf_d    = sf_q;
    of_d    = of_q;
    if (!stall) begin
      if (take) begin
        valid_d = 1'b1;
        icode_d = icode;
        cnd_d   = cnd;
        vale_d  = alu_r;
        vala_d  = valA;
        dste_d  = (icode == I_RRMV && !cnd) ? R_NONE : dstE;
        dstm_d  = dstM;
        if (icode == I_OPL) begin
          zf_d = (alu_r == 32'd0);
          sf_d = alu_r[31];
          of_d = alu_of;
        end
      end else begin
        valid_d = 1'b0;
        icode_d = I_NOP;
        cnd_d   = 1'b0;
        vale_d  = 32'd0;
        vala_d  = 32'd0;
        dste_d  = R_NONE;
        dstm_d  = R_NONE;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= 1'b0;
      icode_q <= I_NOP;
      cnd_q   <= 1'b0;
      vale_q  <= 32'd0;
      vala_q  <= 32'd0;
      dste_q  <= R_NONE;
      dstm_q  <= R_NONE;
      zf_q    <= 1'b1;
      sf_q    <= 1'b0;
      of_q    <= 1'b0;
    end else begin
      valid_q <= valid_d;
      icode_q <= icode_d;
      cnd_q   <= cnd_d;
      vale_q  <= vale_d;
      vala_q  <= vala_d;
      dste_q  <= dste_d;
      dstm_q  <= dstm_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
      of_q    <= of_d;
    end
  end

  assign out_valid = valid_q;
  assign out_icode = icode_q;
  assign out_Cnd   = cnd_q;
  assign out_valE  = vale_q;
  assign out_valA  = vala_q;
  assign out_dstE  = dste_q;
  assign out_dstM  = dstm_q;
  assign ZF        = zf_q;
  assign SF        = sf_q;
  assign OF        = of_q;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage with a behavioural reference model.
// Build with EXEC_HALT_LATCH_EN defined to also exercise the halt latch.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        in_valid = 1'b0;
  logic [3:0]  icode = 4'h1, ifun = 4'h0;
  logic [31:0] valA = 0, valB = 0, valC = 0;
  logic [3:0]  dstE = 4'hF, dstM = 4'hF;
  logic        stall = 1'b0, bubble = 1'b0;
  logic        out_valid, out_Cnd, ZF, SF, OF, halted;
  logic [3:0]  out_icode, out_dstE, out_dstM;
  logic [31:0] out_valE, out_valA;

  execute_stage dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid),
    .icode(icode), .ifun(ifun),
    .valA(valA), .valB(valB), .valC(valC),
    .dstE(dstE), .dstM(dstM),
    .stall(stall), .bubble(bubble),
    .out_valid(out_valid), .out_icode(out_icode),
    .out_Cnd(out_Cnd), .out_valE(out_valE),
    .out_valA(out_valA), .out_dstE(out_dstE),
    .out_dstM(out_dstM),
    .ZF(ZF), .SF(SF), .OF(OF), .halted(halted)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          v;
    bit [3:0]    ic;
    bit          cnd;
    bit [31:0]   ve;
    bit [31:0]   va;
    bit [3:0]    de;
    bit [3:0]    dm;
    bit          zf, sf, of, h;
  } st_t;

  st_t m;
  st_t sb[$];
  int  tests = 0;
  int  fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic st_t reset_state();
    st_t s;
    s.v = 0; s.ic = 4'h1; s.cnd = 0; s.ve = 0; s.va = 0;
    s.de = 4'hF; s.dm = 4'hF; s.zf = 1; s.sf = 0; s.of = 0; s.h = 0;
    return s;
  endfunction

  // Reference: plain signed arithmetic, overflow as out-of-range result.
  function automatic st_t model(input st_t s, input bit rst, v,
      input bit [3:0] ic, fn, input bit [31:0] a, b, c,
      input bit [3:0] de, dm, input bit st, bb);
    st_t n = s;
    bit [31:0] xa, xb, r;
    longint wide;
    bit ov, cd, lt;
    if (rst) return reset_state();
    if (st) return s;
    if (bb || !v || s.h) begin
      n.v = 0; n.ic = 4'h1; n.cnd = 0; n.ve = 0; n.va = 0;
      n.de = 4'hF; n.dm = 4'hF;
      return n;
    end
    if (ic == 2 || ic == 6) xa = a;
    else if (ic >= 3 && ic <= 5) xa = c;
    else if (ic == 8 || ic == 'hA) xa = 32'hFFFF_FFFC;
    else if (ic == 9 || ic == 'hB) xa = 4;
    else xa = 0;
    xb = (ic inside {4, 5, 6, 8, 9, 'hA, 'hB}) ? b : 0;
    wide = longint'($signed(xb)) + longint'($signed(xa));
    if (ic == 6 && fn == 1)
      wide = longint'($signed(xb)) - longint'($signed(xa));
    r  = wide[31:0];
    ov = (wide > 64'sd2147483647) || (wide < -64'sd2147483648);
    if (ic == 6 && fn == 2) begin r = xa & xb; ov = 0; end
    if (ic == 6 && fn == 3) begin r = xa ^ xb; ov = 0; end
    lt = (s.sf != s.of);
    case (fn)
      0: cd = 1;
      1: cd = lt || s.zf;
      2: cd = lt;
      3: cd = s.zf;
      4: cd = !s.zf;
      5: cd = !lt;
      6: cd = !lt && !s.zf;
      default: cd = 0;
    endcase
    n.v = 1; n.ic = ic; n.cnd = cd; n.ve = r; n.va = a;
    n.de = (ic == 2 && !cd) ? 4'hF : de;
    n.dm = dm;
    if (ic == 6) begin
      n.zf = (r == 0); n.sf = r[31]; n.of = ov;
    end
`ifdef EXEC_HALT_LATCH_EN
    if (ic == 0 || ic > 4'hB) n.h = 1;
`endif
    return n;
  endfunction

  task automatic drive(input bit rst, v, input bit [3:0] ic, fn,
      input bit [31:0] a, b, c, input bit [3:0] de, dm,
      input bit st, bb);
    @(negedge CLK);
    RST = rst; in_valid = v; icode = ic; ifun = fn;
    valA = a; valB = b; valC = c; dstE = de; dstM = dm;
    stall = st; bubble = bb;
    m = model(m, rst, v, ic, fn, a, b, c, de, dm, st, bb);
    sb.push_back(m);
  endtask

  task automatic after_edge();
    @(posedge CLK);
    #2;
  endtask

  always @(posedge CLK) begin
    st_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("out_valid", 32'(out_valid), 32'(e.v));
      chk("out_icode", 32'(out_icode), 32'(e.ic));
      chk("out_Cnd", 32'(out_Cnd), 32'(e.cnd));
      chk("out_valE", out_valE, e.ve);
      chk("out_valA", out_valA, e.va);
      chk("out_dstE", 32'(out_dstE), 32'(e.de));
      chk("out_dstM", 32'(out_dstM), 32'(e.dm));
      chk("ZF", 32'(ZF), 32'(e.zf));
      chk("SF", 32'(SF), 32'(e.sf));
      chk("OF", 32'(OF), 32'(e.of));
      chk("halted", 32'(halted), 32'(e.h));
    end
  end

  function automatic bit [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h7FFF_FFFF;
      1: return 32'h8000_0000;
      2: return 32'($urandom_range(0, 3));
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit [3:0] ic, fn;
    m = reset_state();
    drive(1, 0, 1, 0, 0, 0, 0, 15, 15, 0, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 15, 15, 0, 0);
    after_edge();
    chk("rst_icode", 32'(out_icode), 32'h1);
    chk("rst_zf", 32'(ZF), 32'h1);

    drive(0, 1, 6, 1, 5, 5, 0, 2, 15, 0, 0);
    after_edge();
    chk("sub_valE", out_valE, 32'h0);
    chk("sub_flags", {ZF, SF, OF}, 3'b100);

    drive(0, 1, 6, 0, 32'h7FFF_FFFF, 1, 0, 2, 15, 0, 0);
    after_edge();
    chk("ovf_valE", out_valE, 32'h8000_0000);
    chk("ovf_flags", {ZF, SF, OF}, 3'b011);

    drive(0, 1, 6, 1, 5, 5, 0, 2, 15, 0, 0);
    drive(0, 1, 2, 4, 7, 0, 0, 3, 15, 0, 0);
    after_edge();
    chk("cmovne", {out_Cnd, out_dstE}, 5'h0F);
    drive(0, 1, 2, 3, 7, 0, 0, 3, 15, 0, 0);
    after_edge();
    chk("cmove", {out_Cnd, out_dstE}, 5'h13);

    drive(0, 1, 'hA, 0, 9, 32'h100, 0, 4, 15, 0, 0);
    after_edge();
    chk("push_valE", out_valE, 32'hFC);
    drive(0, 1, 'hB, 0, 0, 32'h100, 0, 4, 4, 0, 0);
    after_edge();
    chk("pop_valE", out_valE, 32'h104);
    chk("pop_cc", {ZF, SF, OF}, 3'b100);

    drive(0, 1, 6, 0, 1, 2, 0, 1, 15, 1, 1);
    drive(0, 1, 6, 0, 3, 4, 0, 1, 15, 1, 1);
    after_edge();
    chk("stall_valE", out_valE, 32'h104);
    drive(0, 1, 6, 0, 3, 4, 0, 1, 15, 0, 1);
    after_edge();
    chk("bubble", {out_valid, out_icode}, 5'h01);
    drive(0, 1, 3, 0, 0, 0, 42, 5, 15, 0, 0);
    drive(1, 1, 6, 0, 3, 4, 0, 1, 15, 1, 0);
    after_edge();
    chk("rst_mid", {out_valid, out_icode, out_dstE}, 9'h01F);

    for (int i = 0; i < 500; i++) begin
`ifdef EXEC_HALT_LATCH_EN
      ic = 4'($urandom_range(1, 11));
`else
      ic = 4'($urandom_range(0, 15));
`endif
      fn = (ic == 6) ? 4'($urandom_range(0, 3))
                     : 4'($urandom_range(0, 8));
      drive(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0),
            ic, fn, pick_val(), pick_val(), pick_val(),
            4'($urandom), 4'($urandom),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
    end

`ifdef EXEC_HALT_LATCH_EN
    drive(1, 0, 1, 0, 0, 0, 0, 15, 15, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0, 15, 15, 0, 0);
    after_edge();
    chk("halt_set", 32'(halted), 32'h1);
    drive(0, 1, 6, 0, 1, 1, 0, 2, 15, 0, 0);
    after_edge();
    chk("halt_nop", {out_valid, ZF}, 2'b01);
    drive(1, 0, 1, 0, 0, 0, 0, 15, 15, 0, 0);
    after_edge();
    chk("halt_clr", 32'(halted), 32'h0);
`endif

    drive(0, 0, 1, 0, 0, 0, 0, 15, 15, 0, 0);
    repeat (3) @(negedge CLK);
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 The block SHALL use a single clock and synchronous active-high reset: CLK and RST.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous active-high reset
- in_valid  in  1  decode outputs valid this cycle
- icode  in  4  instruction code (0 halt .. B popl)
- ifun  in  4  function code
- valA  in  32  register-file port A value
- valB  in  32  register-file port B value
- valC  in  32  instruction constant
- dstE  in  4  destE register ID (F = none)
- dstM  in  4  destM register ID (F = none)
- stall  in  1  hold E/M register and CC
- bubble  in  1  insert nop into E/M register
- out_valid  out  1  E/M register holds a valid instruction
- out_icode  out  4  registered icode
- out_Cnd  out  1  registered condition result
- out_valE  out  32  registered ALU result
- out_valA  out  32  registered valA (store data)
- out_dstE  out  4  registered destE, after cmov squash
- out_dstM  out  4  registered destM
- ZF, SF, OF  out  1 each  condition-code register
- halted  out  1  halt latched (EXEC_HALT_LATCH_EN only; else tied 0)

Function
REQ-003 aluA SHALL be valA for icode 2/6; valC for 3/4/5; -4 for 8/A; +4 for 9/B; 0 otherwise.
REQ-004 aluB SHALL be valB for icode 4/5/6/8/9/A/B; 0 otherwise.
REQ-005 The ALU SHALL apply ifun for icode 6 (0 add, 1 sub B-A, 2 and, 3 xor) and add for all other icodes; results wrap modulo 2^32.
REQ-006 Cnd SHALL be evaluated from the current CC register value: ifun 0 always, 1 le (SF^OF)|ZF, 2 l SF^OF, 3 e ZF, 4 ne ~ZF, 5 ge ~(SF^OF), 6 g ~(SF^OF)&~ZF; ifun above 6 gives 0.
REQ-007 For icode 2 with Cnd=0, the captured out_dstE SHALL be F; otherwise out_dstE SHALL equal dstE.
REQ-008 Latency SHALL be one cycle: inputs sampled on edge N appear on the outputs after edge N.
REQ-009 The CC register SHALL update only when in_valid=1, icode=6, stall=0 and bubble=0.
- ZF = (result==0).
- SF = result[31].
- OF: add = a,b same sign and result sign differs; sub = B,A signs differ and result sign differs from B; and/xor = 0.
REQ-010 stall=1 SHALL hold every output register and the CC unchanged; stall SHALL take priority over bubble.
REQ-011 bubble=1 with stall=0, or in_valid=0, SHALL load a nop: out_valid 0, out_icode 1, out_dstE F, out_dstM F, out_Cnd 0, out_valE 0, out_valA 0.
REQ-012 Icodes above B SHALL pass through with out_valid 1, valE = 0 + 0, and no CC update.

Reset
REQ-013 RST=1 at a rising edge SHALL set out_valid 0, out_icode 1, out_Cnd 0, out_valE 0, out_valA 0, out_dstE F, out_dstM F, ZF 1, SF 0, OF 0, and halted 0.
REQ-014 RST SHALL override stall and bubble; an instruction in flight at reset SHALL be discarded.

Configuration
REQ-015 With EXEC_HALT_LATCH_EN defined, a captured valid icode 0 or an icode above B SHALL set halted to 1.
- While halted=1, later inputs SHALL load nops and SHALL not update the CC.
- Only RST SHALL clear halted.
REQ-016 Without EXEC_HALT_LATCH_EN, halted SHALL be tied to 0 and icode 0 SHALL pass through as an ordinary instruction.

Verification
REQ-017 OPl sub: valA=5, valB=5, ifun=1 -> next cycle out_valE=0, ZF=1, SF=0, OF=0.
REQ-018 OPl add overflow: valA=0x7FFFFFFF, valB=1, ifun=0 -> out_valE=0x80000000, SF=1, OF=1, ZF=0.
REQ-019 After REQ-017, cmovne (icode 2, ifun 4, dstE=3) -> out_Cnd=0, out_dstE=F; cmove (ifun 3) -> out_Cnd=1, out_dstE=3.
REQ-020 pushl: valB=0x100 -> out_valE=0xFC; popl: valB=0x100 -> out_valE=0x104; CC unchanged in both cases.
REQ-021 Control and reset:
- stall=1 and bubble=1 together for 2 cycles -> outputs and CC frozen.
- bubble alone -> out_icode=1, out_valid=0.
- RST asserted mid-stream -> all outputs reach their REQ-013 values on the next edge.
REQ-022 With EXEC_HALT_LATCH_EN defined, a valid icode 0 -> halted=1; a following OPl add (valA=1, valB=1) -> out_valid=0 and CC unchanged.
